dram_read_scheduler: RTL

Issues DRAM chunk-read requests for every playing instrument voice, in round-robin order. Each request covers one 128-bit chunk of 8 samples. The block sits on the DRAM-controller side, ahead of the DRAM read FIFO that feeds the per-instrument unstackers and the sample mixer. It walks each triggered voice from its start offset to its end offset, limits in-flight chunks per voice with credits, and stalls while the read FIFO is near full.

---
 rtl/dram_sched_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/dram_read_scheduler.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/dram_sched_pkg.sv
// rtl/dram_sched_pkg.sv - shared types and constants for the DRAM read scheduler
package dram_sched_pkg;

  localparam int ADDR_W = 24;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } sched_state_t;

  // Bits needed to hold a credit count in the range 0..max_outstanding.
  function automatic int credit_width(input int max_outstanding);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << w) < (max_outstanding + 1)) begin
        w = w + 1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, search starts at i_ptr and wraps
module rr_arbiter #(
  parameter int N  = 8,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [IW-1:0] w_cand;

  // First requester at or after the pointer wins; the search wraps from N-1 to 0.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = '0;
    for (int i = 0; i < N; i++) begin
      w_cand = IW'((int'(i_ptr) + i) % N);
      if (!o_any && i_req[w_cand]) begin
        o_any          = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_idx          = w_cand;
      end
    end
  end

endmodule

// File: rtl/dram_read_scheduler.sv
// rtl/dram_read_scheduler.sv - round-robin DRAM chunk-read issuer with per-voice credits; optional DRAM_SCHED_STATS_EN adds stat_issued/stat_stall
module dram_read_scheduler
  import dram_sched_pkg::*;
#(
  parameter int INSTRUMENT_COUNT = 8,
  parameter int MAX_OUTSTANDING  = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [INSTRUMENT_COUNT:0][ADDR_W-1:0]  addr_offsets,
  input  logic                                   addr_offsets_valid,
  input  logic [INSTRUMENT_COUNT-1:0]            trigger,
  input  logic [INSTRUMENT_COUNT-1:0]            chunk_consumed,
  input  logic                                   fifo_prog_full,
  output logic                                   req_valid,
  input  logic                                   req_ready,
  output logic [ADDR_W-1:0]                      req_addr,
  output logic [$clog2(INSTRUMENT_COUNT)-1:0]    req_instr,
  output logic [INSTRUMENT_COUNT-1:0]            voice_active
`ifdef DRAM_SCHED_STATS_EN
  ,
  output logic [31:0]                            stat_issued,
  output logic [31:0]                            stat_stall
`endif
);

  localparam int IDX_W  = $clog2(INSTRUMENT_COUNT);
  localparam int CRED_W = credit_width(MAX_OUTSTANDING);
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(MAX_OUTSTANDING);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(INSTRUMENT_COUNT - 1);

  sched_state_t r_state;
  sched_state_t w_next_state;

  logic [INSTRUMENT_COUNT-1:0] r_active;
  logic [ADDR_W-1:0]           r_next_addr [INSTRUMENT_COUNT];
  logic [CRED_W-1:0]           r_credit    [INSTRUMENT_COUNT];
  logic [IDX_W-1:0]            r_rr_ptr;
  logic [ADDR_W-1:0]           r_req_addr;
  logic [IDX_W-1:0]            r_req_instr;

  logic [INSTRUMENT_COUNT-1:0] w_eligible;
  logic [INSTRUMENT_COUNT-1:0] w_grant;
  logic [INSTRUMENT_COUNT-1:0] w_issue;
  logic [IDX_W-1:0]            w_grant_idx;
  logic                        w_any_eligible;
  logic                        w_pick;

  // A voice may be picked only while it still has chunks left and a free credit.
  always_comb begin
    w_eligible = '0;
    for (int i = 0; i < INSTRUMENT_COUNT; i++) begin
      w_eligible[i] = r_active[i] && (r_credit[i] != '0);
    end
  end

  rr_arbiter #(
    .N  (INSTRUMENT_COUNT),
    .IW (IDX_W)
  ) u_rr_arbiter (
    .i_req   (w_eligible),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_grant_idx),
    .o_any   (w_any_eligible)
  );

  // Next-state logic: pick in S_IDLE when the FIFO has room, hold in S_REQ until accepted.
  always_comb begin
    w_next_state = r_state;
    w_pick       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!fifo_prog_full && w_any_eligible) begin
          w_pick       = 1'b1;
          w_next_state = S_REQ;
        end
      end
      S_REQ: begin
        if (req_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_issue = w_pick ? w_grant : '0;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Latch the picked request and move the round-robin pointer past the winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_addr  <= '0;
      r_req_instr <= '0;
      r_rr_ptr    <= '0;
    end else if (w_pick) begin
      r_req_addr  <= r_next_addr[w_grant_idx];
      r_req_instr <= w_grant_idx;
      r_rr_ptr    <= (w_grant_idx == IDX_LAST) ? '0 : w_grant_idx + IDX_W'(1);
    end
  end

  // Per-voice walk and credits; a trigger overrides an end-of-voice in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_active <= '0;
      for (int i = 0; i < INSTRUMENT_COUNT; i++) begin
        r_next_addr[i] <= '0;
        r_credit[i]    <= CRED_MAX;
      end
    end else begin
      for (int i = 0; i < INSTRUMENT_COUNT; i++) begin
        if (trigger[i] && addr_offsets_valid) begin
          r_next_addr[i] <= addr_offsets[i];
          r_active[i]    <= addr_offsets[i] < addr_offsets[i+1];
        end else if (w_issue[i]) begin
          r_next_addr[i] <= r_next_addr[i] + ADDR_W'(1);
          if ((r_next_addr[i] + ADDR_W'(1)) == addr_offsets[i+1]) begin
            r_active[i] <= 1'b0;
          end
        end
        case ({w_issue[i], chunk_consumed[i]})
          2'b10: r_credit[i] <= r_credit[i] - CRED_W'(1);
          2'b01: begin
            if (r_credit[i] != CRED_MAX) begin
              r_credit[i] <= r_credit[i] + CRED_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign req_valid    = (r_state == S_REQ);
  assign req_addr     = r_req_addr;
  assign req_instr    = r_req_instr;
  assign voice_active = r_active;

`ifdef DRAM_SCHED_STATS_EN
  logic [31:0] r_stat_issued;
  logic [31:0] r_stat_stall;

  // Count accepted requests and idle cycles lost to a near-full read FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_issued <= '0;
      r_stat_stall  <= '0;
    end else begin
      if (req_valid && req_ready) begin
        r_stat_issued <= r_stat_issued + 32'd1;
      end
      if ((r_state == S_IDLE) && w_any_eligible && fifo_prog_full) begin
        r_stat_stall <= r_stat_stall + 32'd1;
      end
    end
  end

  assign stat_issued = r_stat_issued;
  assign stat_stall  = r_stat_stall;
`endif

endmodule
